// File: rtl/spi_send_scheduler.sv
// Round-robin arbiter feeding a word FIFO whose head is serialised MSB byte first
// onto the SPI slave byte lane, paced by the SPI core's ready strobe.
module spi_send_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int NUM_SRC        = 4,
    parameter int DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                req,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     data_in,
    output logic [NUM_SRC-1:0]                grant,
    input  logic                              spi_ready,
    input  logic                              spi_start,
    output logic [SPI_DATA_WIDTH-1:0]         data_out_byte,
    output logic                              frame_done,
    output logic                              busy,
    output logic [$clog2(DEPTH):0]            fifo_count,
    output logic                              overflow
);
    localparam int BYTES = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int OW    = $clog2(DEPTH * BYTES + 1);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [OW-1:0] STARVE_LIM = OW'(DEPTH * BYTES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_n;
    logic [CW-1:0]         count, count_n;
    logic [SW-1:0]         rr_ptr;
    logic [BW-1:0]         byte_idx, idx_n;
    logic [OW-1:0]         starve_cnt;
    logic [0:0]            state;
    logic                  spi_ready_q;

    logic                  push, pop, consume, adv, last, starving;
    int unsigned           grant_idx, arb_src;
    logic [DATA_WIDTH-1:0] push_word, head_n;
    logic [SPI_DATA_WIDTH-1:0] byte_n;

    // Fullness uses the pre-pop count, so a full FIFO never grants in its pop cycle.
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        grant_idx = 0;
        arb_src   = 0;
        if (!rst && count < FULL_CNT) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                arb_src = (32'(rr_ptr) + k) % NUM_SRC;
                if (!push && req[arb_src]) begin
                    push             = 1'b1;
                    grant_idx        = arb_src;
                    grant[arb_src]   = 1'b1;
                end
            end
        end
    end

    assign push_word = data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    assign consume  = spi_ready_q & ~spi_ready;
    assign last     = (byte_idx == LAST_BYTE);
    assign adv      = consume & (count != '0) & ~spi_start;
    assign pop      = adv & last;
    assign starving = (|req) && (count == FULL_CNT);

    always_comb begin
        idx_n = byte_idx;
        if (spi_start)
            idx_n = '0;
        else if (adv)
            idx_n = last ? '0 : byte_idx + BW'(1);
    end

    assign rd_n = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // The output byte is registered, so it is built from the post-edge head; a word
    // written this cycle that becomes the head has to bypass the memory.
    always_comb begin
        head_n = mem[rd_n];
        if (push && rd_n == wr_ptr)
            head_n = push_word;
        byte_n = '0;
        if (count_n != '0)
            byte_n = head_n[DATA_WIDTH-1-int'(idx_n)*SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rr_ptr        <= '0;
            byte_idx      <= '0;
            spi_ready_q   <= 1'b0;
            data_out_byte <= '0;
            frame_done    <= 1'b0;
            state         <= IDLE;
            starve_cnt    <= '0;
            overflow      <= 1'b0;
        end else begin
            spi_ready_q   <= spi_ready;
            byte_idx      <= idx_n;
            rd_ptr        <= rd_n;
            count         <= count_n;
            data_out_byte <= byte_n;
            frame_done    <= pop;
            state         <= (count_n != '0) ? SEND : IDLE;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= SW'((grant_idx + 1) % NUM_SRC);
            end
            if (pop || !starving)
                starve_cnt <= '0;
            else if (consume) begin
                if (starve_cnt == STARVE_LIM)
                    overflow <= 1'b1;
                else
                    starve_cnt <= starve_cnt + OW'(1);
            end
        end
    end

    assign busy       = (state == SEND);
    assign fifo_count = count;

endmodule
